// File: rtl/tag_reclaim_queue_if.sv
// Bundle of the allocate/commit/collect signals of the tag reclaim queue.
// The master drives pushes, commits and flushes. The slave (the queue) drives
// the collect port toward the freelist and its status outputs.
interface tag_reclaim_queue_if #(
    parameter int ENTRY = 16,
    parameter int IN    = 4,
    parameter int OUT   = 4,
    parameter int DATA  = 16
);
    logic                         flush_;
    logic [IN-1:0]                push_;
    logic [IN*DATA-1:0]           push_tag;
    logic [$clog2(OUT+1)-1:0]     commit_cnt;
    logic [OUT-1:0]               we_;
    logic [OUT*DATA-1:0]          wd;
    logic [$clog2(ENTRY):0]       count;
    logic                         full;
    logic                         ovf;
    logic                         udf;

    modport master (
        output flush_, push_, push_tag, commit_cnt,
        input  we_, wd, count, full, ovf, udf
    );

    modport slave (
        input  flush_, push_, push_tag, commit_cnt,
        output we_, wd, count, full, ovf, udf
    );
endinterface

// File: rtl/tag_reclaim_queue.sv
// In-order holding queue for allocated tags. Tags enter in program order.
// On commit, the oldest tags are handed back to the freelist collect port
// one cycle later.
module tag_reclaim_queue #(
    parameter int DEPTH   = 16,
    parameter int ENTRY   = 16,
    parameter int IN      = 4,
    parameter int OUT     = 4,
    parameter int BIT_VEC = 1
) (
    input  logic               clk,
    input  logic               reset,
    tag_reclaim_queue_if.slave bus
);
    localparam int DATA = (BIT_VEC != 0) ? DEPTH : $clog2(DEPTH);
    localparam int PW   = $clog2(ENTRY);
    localparam int CW   = PW + 1;

    logic [PW-1:0]       head_q, head_d;
    logic [PW-1:0]       tail_q, tail_d;
    logic [CW-1:0]       count_q, count_d;
    logic                ovf_q, ovf_d;
    logic                udf_q, udf_d;
    logic [OUT-1:0]      we_n_q, we_n_d;
    logic [OUT*DATA-1:0] wd_q, wd_d;
    logic [DATA-1:0]     mem_q [ENTRY];
    logic [DATA-1:0]     mem_d [ENTRY];

    logic                full;
    logic [CW-1:0]       npush;
    logic [CW-1:0]       npush_acc;
    logic [CW-1:0]       npop;
    logic [CW-1:0]       cc;
    logic [PW-1:0]       off;

    // Next state: push compaction, commit clamping, release staging and flush.
    always_comb begin
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;
        ovf_d     = ovf_q;
        udf_d     = udf_q;
        mem_d     = mem_q;
        we_n_d    = '1;
        wd_d      = '0;
        npush_acc = '0;
        off       = '0;

        // Full is taken from the registered count, so it is known before this cycle's pushes.
        full = count_q > CW'(ENTRY - IN);

        npush = '0;
        for (int i = 0; i < IN; i++) begin
            if (!bus.push_[i]) npush = npush + CW'(1);
        end

        // Only entries already registered can be popped this cycle.
        cc   = CW'(bus.commit_cnt);
        npop = cc;
        if (npop > count_q) npop = count_q;
        if (npop > CW'(OUT)) npop = CW'(OUT);

        if (!bus.flush_) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (full && (npush != '0)) ovf_d = 1'b1;
            if (cc > count_q) udf_d = 1'b1;
            if (!full) npush_acc = npush;

            for (int i = 0; i < IN; i++) begin
                if (!bus.push_[i] && !full) begin
                    mem_d[tail_q + off] = bus.push_tag[i*DATA +: DATA];
                    off = off + PW'(1);
                end
            end

            for (int k = 0; k < OUT; k++) begin
                if (CW'(k) < npop) begin
                    we_n_d[k]              = 1'b0;
                    wd_d[k*DATA +: DATA]   = mem_q[head_q + PW'(k)];
                end
            end

            head_d  = head_q + npop[PW-1:0];
            tail_d  = tail_q + npush_acc[PW-1:0];
            count_d = count_q + npush_acc - npop;
        end
    end

    // Control state and the registered release port, with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
            we_n_q  <= '1;
            wd_q    <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
            we_n_q  <= we_n_d;
            wd_q    <= wd_d;
        end
    end

    // Tag storage. It has no reset because only occupied slots are ever read.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign bus.count = count_q;
    assign bus.full  = full;
    assign bus.ovf   = ovf_q;
    assign bus.udf   = udf_q;
    assign bus.we_   = we_n_q;
    assign bus.wd    = wd_q;
endmodule
